// File: rtl/pad_bus_pkg.sv
// Shared types and encodings for the pad-ring bus master: FSM states,
// pad output-enable levels and bus direction.
package pad_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TURN,
    STB_HI,
    STB_LO,
    DONE,
    ERR
  } state_t;

  localparam logic OEN_DRIVE = 1'b0;
  localparam logic OEN_TRI   = 1'b1;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

endpackage

// File: rtl/pad_sync2.sv
// Generic two-flop synchronizer for asynchronous pad inputs; both flops
// clear to zero on synchronous reset.
module pad_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_p0 <= '0;
      q       <= '0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/pad_bidir_bus_master.sv
// Core-side master for a half-duplex pad bus: turns single-word requests into
// a 4-phase strobe/ack handshake and owns pad direction, turnaround and timeout.
module pad_bidir_bus_master
  import pad_bus_pkg::*;
#(
  parameter int DW = 8,
  parameter int TA = 2,
  parameter int TO = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [DW-1:0] pad_i,
  output logic [DW-1:0] pad_oen,
  input  logic [DW-1:0] pad_c,
  output logic          stb_i,
  input  logic          ack_c
);

  localparam int TW = $clog2(TO + 1);

  state_t        state, state_d;
  logic          dir, wr_q, oen, stb, ack_s;
  logic [DW-1:0] wdata_q, wdata_next;
  logic [TW-1:0] timer;
  logic [3:0]    turn_cnt;
  logic          accept, wr_next, timeout, turn_done, enter_stb;

  pad_sync2 #(.W(1)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ack_c),
    .q     (ack_s)
  );

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign timeout    = (timer == TW'(TO - 1));
  assign turn_done  = (turn_cnt == 4'(TA - 1));
  // A same-direction request skips TURN, so its fields come straight from the port.
  assign wr_next    = (state == IDLE) ? req_wr : wr_q;
  assign wdata_next = (state == IDLE) ? req_wdata : wdata_q;
  assign enter_stb  = (state != STB_HI) && (state_d == STB_HI);
  assign pad_oen    = {DW{oen}};
  assign stb_i      = stb;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (accept) state_d = (req_wr != dir) ? TURN : STB_HI;
      TURN:    if (turn_done) state_d = STB_HI;
      STB_HI:  if (ack_s) state_d = STB_LO;
               else if (timeout) state_d = ERR;
      STB_LO:  if (!ack_s) state_d = DONE;
               else if (timeout) state_d = ERR;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) wdata_q <= req_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dir       <= READ;
      wr_q      <= READ;
      oen       <= OEN_TRI;
      pad_i     <= '0;
      stb       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      timer     <= '0;
      turn_cnt  <= '0;
    end else begin
      state     <= state_d;
      stb       <= (state_d == STB_HI);
      rsp_valid <= (state_d == DONE) || (state_d == ERR);
      rsp_err   <= (state_d == ERR);

      // Timers restart on every state change and saturate rather than wrap.
      if (state_d != state) timer <= '0;
      else if ((state == STB_HI || state == STB_LO) && timer != TW'(TO)) timer <= timer + 1'b1;
      if (state_d != state) turn_cnt <= '0;
      else if (state == TURN) turn_cnt <= turn_cnt + 1'b1;

      if (accept) wr_q <= req_wr;
      // Release a parked write bus as soon as a read is accepted.
      if (accept && req_wr == READ && dir == WRITE) oen <= OEN_TRI;
      if (enter_stb && wr_next == WRITE) begin
        pad_i <= wdata_next;
        oen   <= OEN_DRIVE;
      end
      if (state == TURN && state_d == STB_HI) dir <= wr_q;
      if (state == STB_HI && ack_s && wr_q == READ) rsp_rdata <= pad_c;
      if (state_d == ERR) begin
        oen <= OEN_TRI;
        dir <= READ;
      end
    end
  end

endmodule

// File: tb/tb_pad_bidir_bus_master.sv
// Directed bench for pad_bidir_bus_master: reset, write, read turnaround,
// back-to-back reads, timeout and mid-transaction reset.
module tb_pad_bidir_bus_master;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset, req_valid, req_wr, ack_c;
  logic [DW-1:0] req_wdata, pad_c;
  logic          req_ready, rsp_valid, rsp_err, stb_i;
  logic [DW-1:0] rsp_rdata, pad_i, pad_oen;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int n;
  logic seen;

  always #5 clk = ~clk;

  pad_bidir_bus_master #(.DW(DW), .TA(2), .TO(255)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .pad_i     (pad_i),
    .pad_oen   (pad_oen),
    .pad_c     (pad_c),
    .stb_i     (stb_i),
    .ack_c     (ack_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // which: 0 = stb_i, 1 = rsp_valid; cnt = negedges until match, -1 on expiry
  task automatic wait_sig(input int which, input logic val, input int max, output int cnt);
    cnt = -1;
    for (int i = 1; i <= max && cnt < 0; i++) begin
      @(negedge clk);
      if (((which == 0) ? stb_i : rsp_valid) === val) cnt = i;
    end
  endtask

  task automatic issue(input logic wr, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_wr    = wr;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [DW-1:0] v);
    int k;
    @(negedge clk);
    chk1("rd_ready", req_ready, 1'b1);
    issue(1'b0, 8'h00);
    chk1("rd_stb_no_turn", stb_i, 1'b1);
    chk("rd_oen", 32'(pad_oen), 32'h0000_00FF);
    pad_c = v;
    ack_c = 1'b1;
    wait_sig(0, 1'b0, 20, k);
    chk("rd_stb_fall_lat", 32'(k), 32'd3);
    ack_c = 1'b0;
    pad_c = 8'h00;
    wait_sig(1, 1'b1, 20, k);
    chk("rd_rsp_lat", 32'(k), 32'd3);
    chk("rd_rdata", 32'(rsp_rdata), 32'(v));
    chk1("rd_err", rsp_err, 1'b0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_wdata = '0;
    pad_c = '0; ack_c = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_oen", 32'(pad_oen), 32'h0000_00FF);
    chk1("rst_stb", stb_i, 1'b0);
    chk("rst_pad_i", 32'(pad_i), 32'h0);
    chk1("rst_ready", req_ready, 1'b1);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rdata", 32'(rsp_rdata), 32'h0);

    // Write A5 from reset: direction changes, so two TURN cycles first
    issue(1'b1, 8'hA5);
    chk("wr_turn1_oen", 32'(pad_oen), 32'h0000_00FF);
    chk1("wr_turn1_stb", stb_i, 1'b0);
    chk1("wr_busy", req_ready, 1'b0);
    @(negedge clk);
    chk("wr_turn2_oen", 32'(pad_oen), 32'h0000_00FF);
    chk1("wr_turn2_stb", stb_i, 1'b0);
    @(negedge clk);
    chk1("wr_stb_hi", stb_i, 1'b1);
    chk("wr_oen_drive", 32'(pad_oen), 32'h0);
    chk("wr_pad_i", 32'(pad_i), 32'h0000_00A5);
    repeat (3) @(negedge clk);
    ack_c = 1'b1;
    wait_sig(0, 1'b0, 20, n);
    chk("wr_stb_fall_lat", 32'(n), 32'd3);
    repeat (2) @(negedge clk);
    ack_c = 1'b0;
    wait_sig(1, 1'b1, 20, n);
    chk("wr_rsp_lat", 32'(n), 32'd3);
    chk1("wr_err", rsp_err, 1'b0);
    @(negedge clk);
    chk1("wr_rsp_pulse", rsp_valid, 1'b0);
    chk("wr_park_oen", 32'(pad_oen), 32'h0);
    chk("wr_park_pad_i", 32'(pad_i), 32'h0000_00A5);
    chk1("wr_idle_ready", req_ready, 1'b1);

    // Read after write: bus released the cycle after acceptance
    issue(1'b0, 8'h00);
    chk("raw_oen", 32'(pad_oen), 32'h0000_00FF);
    chk1("raw_stb", stb_i, 1'b0);
    wait_sig(0, 1'b1, 20, n);
    chk("raw_stb_rise_lat", 32'(n), 32'd2);
    pad_c = 8'h3C;
    ack_c = 1'b1;
    wait_sig(0, 1'b0, 20, n);
    chk("raw_stb_fall_lat", 32'(n), 32'd3);
    ack_c = 1'b0;
    pad_c = 8'h00;
    wait_sig(1, 1'b1, 20, n);
    chk("raw_rsp_lat", 32'(n), 32'd3);
    chk("raw_rdata", 32'(rsp_rdata), 32'h0000_003C);
    chk1("raw_err", rsp_err, 1'b0);
    @(negedge clk);
    chk("raw_rdata_hold", 32'(rsp_rdata), 32'h0000_003C);
    chk1("raw_rsp_pulse", rsp_valid, 1'b0);

    // Back-to-back reads in the same direction
    do_read(8'h11);
    do_read(8'h22);

    // Timeout: write with no acknowledge
    @(negedge clk);
    issue(1'b1, 8'h5A);
    chk1("to_turn_stb", stb_i, 1'b0);
    wait_sig(0, 1'b1, 20, n);
    chk("to_stb_rise_lat", 32'(n), 32'd2);
    wait_sig(0, 1'b0, 400, n);
    chk("to_stb_hi_cycles", 32'(n), 32'd255);
    chk1("to_rsp_valid", rsp_valid, 1'b1);
    chk1("to_rsp_err", rsp_err, 1'b1);
    chk("to_oen", 32'(pad_oen), 32'h0000_00FF);
    @(negedge clk);
    chk1("to_rsp_pulse", rsp_valid, 1'b0);
    chk1("to_ready", req_ready, 1'b1);
    issue(1'b1, 8'hC3);
    chk1("to_next_turn_stb", stb_i, 1'b0);
    chk("to_next_turn_oen", 32'(pad_oen), 32'h0000_00FF);
    wait_sig(0, 1'b1, 20, n);
    chk("to_next_rise_lat", 32'(n), 32'd2);
    chk("to_next_pad_i", 32'(pad_i), 32'h0000_00C3);

    // Reset while in STB_HI
    reset = 1'b1;
    @(negedge clk);
    chk1("mr_stb", stb_i, 1'b0);
    chk("mr_oen", 32'(pad_oen), 32'h0000_00FF);
    chk1("mr_rsp_valid", rsp_valid, 1'b0);
    chk("mr_pad_i", 32'(pad_i), 32'h0);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk1("mr_no_rsp", seen, 1'b0);
    chk1("mr_ready", req_ready, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
